// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC router.
//   N_PORTS / P_L..P_W : port count and port indices (0=L,1=N,2=E,3=S,4=W)
//   port_idx_t         : 3-bit port index
//   port_mask_t        : one bit per port
//   get_dx / get_dy    : extract destination coordinates from a flit that has been
//                        zero-extended to FLIT_MAX bits (flits up to 64 bits wide)
package noc_pkg;

  localparam int N_PORTS  = 5;
  localparam int FLIT_MAX = 64;

  typedef logic [2:0]         port_idx_t;
  typedef logic [N_PORTS-1:0] port_mask_t;

  localparam port_idx_t P_L = 3'd0;
  localparam port_idx_t P_N = 3'd1;
  localparam port_idx_t P_E = 3'd2;
  localparam port_idx_t P_S = 3'd3;
  localparam port_idx_t P_W = 3'd4;

  // dest x occupies the top CW bits of the DW-bit flit
  function automatic logic [31:0] get_dx(input logic [FLIT_MAX-1:0] flit, input int dw, input int cw);
    logic [FLIT_MAX-1:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    return 32'((flit >> (dw - cw)) & mask);
  endfunction

  // dest y sits directly below dest x
  function automatic logic [31:0] get_dy(input logic [FLIT_MAX-1:0] flit, input int dw, input int cw);
    logic [FLIT_MAX-1:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    return 32'((flit >> (dw - 2 * cw)) & mask);
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// Input flit FIFO for one router port.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   wr_en      : push wr_data this edge
//   rd_en      : pop the head this edge (ignored when empty)
//   head       : current head flit (valid when !empty)
//   empty      : FIFO holds no flits
//   overflow   : push attempted while full and not popped; the flit is dropped
module router_in_fifo #(
  parameter int DW        = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          overflow
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DW-1:0] mem [BUF_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, do_rd, do_wr;

  // Extra MSB on each pointer distinguishes full from empty.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_rd    = rd_en && !empty;
  // A full FIFO being popped on the same edge still has room for the write.
  assign do_wr    = wr_en && (!full || do_rd);
  assign overflow = wr_en && full && !do_rd;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mesh_router.sv
// 5-port mesh router (L,N,E,S,W) with XY routing, per-output round-robin
// arbitration and credit-based flow control. PORT_EN trims ports for edge/corner tiles.
//   clk, reset : clock, async active-high reset
//   data_i     : inbound flits, slice p = port p
//   valid_i    : inbound flit valid per port
//   credit_i   : per-output pulse, downstream freed one slot
//   data_o     : registered outbound flits (hold when idle)
//   valid_o    : registered outbound valid
//   credit_o   : per-input pulse, one flit popped from that input FIFO
//   err_o      : sticky; FIFO overflow or route to a disabled port
module mesh_router
  import noc_pkg::*;
#(
  parameter int         DW        = 16,
  parameter int         CW        = 3,
  parameter int         X_COORD   = 0,
  parameter int         Y_COORD   = 0,
  parameter int         BUF_DEPTH = 4,
  parameter port_mask_t PORT_EN   = 5'b11111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS*DW-1:0] data_i,
  input  logic [N_PORTS-1:0]    valid_i,
  input  logic [N_PORTS-1:0]    credit_i,
  output logic [N_PORTS*DW-1:0] data_o,
  output logic [N_PORTS-1:0]    valid_o,
  output logic [N_PORTS-1:0]    credit_o,
  output logic                  err_o
);

  localparam int             CRW    = $clog2(BUF_DEPTH + 1);
  localparam logic [CRW-1:0] CR_MAX = CRW'(BUF_DEPTH);
  localparam logic [CRW-1:0] CR_ONE = CRW'(1);
  localparam logic [31:0]    X_U    = 32'(X_COORD);
  localparam logic [31:0]    Y_U    = 32'(Y_COORD);

  logic [DW-1:0]  head   [N_PORTS];
  logic [31:0]    dx     [N_PORTS];
  logic [31:0]    dy     [N_PORTS];
  port_idx_t      route  [N_PORTS];
  port_idx_t      winner [N_PORTS];
  port_idx_t      rr_ptr [N_PORTS];
  logic [CRW-1:0] credit [N_PORTS];
  port_mask_t     empty, ovf, drop, grant, pop;

  // Disabled ports have no FIFO: they look permanently empty and ignore valid_i.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    if (PORT_EN[p]) begin : g_en
      router_in_fifo #(.DW(DW), .BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (valid_i[p]),
        .wr_data  (data_i[p*DW +: DW]),
        .rd_en    (pop[p]),
        .head     (head[p]),
        .empty    (empty[p]),
        .overflow (ovf[p])
      );
    end else begin : g_dis
      assign head[p]  = '0;
      assign empty[p] = 1'b1;
      assign ovf[p]   = 1'b0;
    end
  end

  // Unused slices of disabled ports are read here only to keep lint quiet.
  logic unused_in;
  assign unused_in = ^{data_i, valid_i, credit_i};

  // XY route of every head; heads bound for a disabled port are discarded.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      dx[p] = get_dx(FLIT_MAX'(head[p]), DW, CW);
      dy[p] = get_dy(FLIT_MAX'(head[p]), DW, CW);
      if (dx[p] > X_U)      route[p] = P_E;
      else if (dx[p] < X_U) route[p] = P_W;
      else if (dy[p] > Y_U) route[p] = P_S;
      else if (dy[p] < Y_U) route[p] = P_N;
      else                  route[p] = P_L;
      drop[p] = !empty[p] && !PORT_EN[route[p]];
    end
  end

  // Per-output round-robin: scan inputs starting at rr_ptr, first requester wins.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < N_PORTS; o++) begin
      grant[o]  = 1'b0;
      winner[o] = P_L;
      if (PORT_EN[o] && credit[o] != '0) begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx = (int'(rr_ptr[o]) + k) % N_PORTS;
          if (!grant[o] && !empty[idx] && route[idx] == port_idx_t'(o)) begin
            grant[o]  = 1'b1;
            winner[o] = port_idx_t'(idx);
          end
        end
      end
    end
  end

  // Each input requests one output only, so the winners never collide.
  always_comb begin
    pop = drop;
    for (int o = 0; o < N_PORTS; o++) begin
      if (grant[o]) pop[winner[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o   <= '0;
      valid_o  <= '0;
      credit_o <= '0;
      err_o    <= 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        credit[o] <= CR_MAX;
        rr_ptr[o] <= P_L;
      end
    end else begin
      valid_o  <= grant;
      credit_o <= pop;
      err_o    <= err_o | (|ovf) | (|drop);
      for (int o = 0; o < N_PORTS; o++) begin
        if (grant[o]) begin
          data_o[o*DW +: DW] <= head[winner[o]];
          rr_ptr[o]          <= (winner[o] == P_W) ? P_L : winner[o] + 3'd1;
        end
        if (grant[o] && !credit_i[o])
          credit[o] <= credit[o] - CR_ONE;
        else if (!grant[o] && credit_i[o] && PORT_EN[o] && credit[o] != CR_MAX)
          credit[o] <= credit[o] + CR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mesh_router.sv
// Bench for mesh_router. Two tiles: an interior router at (1,1) and a corner-style
// tile (L,E,S only) whose X is set to 1, so westbound flits hit a disabled port.
// A queue-based reference model predicts every output each cycle.
module tb_mesh_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [79:0] din  [2];
  logic [4:0]  vin  [2];
  logic [4:0]  cin  [2];
  logic [4:0]  man  [2];
  logic [4:0]  amask[2];
  logic [79:0] dout [2];
  logic [4:0]  vout [2];
  logic [4:0]  cout [2];
  logic        err  [2];

  mesh_router #(.DW(16), .CW(3), .X_COORD(1), .Y_COORD(1), .BUF_DEPTH(4), .PORT_EN(5'b11111)) u_mid (
    .clk(clk), .reset(rst), .data_i(din[0]), .valid_i(vin[0]), .credit_i(cin[0]),
    .data_o(dout[0]), .valid_o(vout[0]), .credit_o(cout[0]), .err_o(err[0]));

  mesh_router #(.DW(16), .CW(3), .X_COORD(1), .Y_COORD(0), .BUF_DEPTH(4), .PORT_EN(5'b01101)) u_cor (
    .clk(clk), .reset(rst), .data_i(din[1]), .valid_i(vin[1]), .credit_i(cin[1]),
    .data_o(dout[1]), .valid_o(vout[1]), .credit_o(cout[1]), .err_o(err[1]));

  // reference model state
  int          mx [2] = '{1, 1};
  int          my [2] = '{1, 0};
  logic [4:0]  men[2] = '{5'b11111, 5'b01101};
  logic [15:0] mq [2][5][$];
  int          mcred[2][5];
  int          mptr [2][5];
  logic [15:0] ed   [2][5];
  logic [4:0]  ev[2], ec[2];
  logic        ee[2];

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(int x, int y, int pl);
    return {3'(x), 3'(y), 10'(pl)};
  endfunction

  function automatic int route_of(int i, logic [15:0] f);
    int dx, dy;
    dx = int'(f[15:13]);
    dy = int'(f[12:10]);
    if (dx > mx[i]) return 2;
    if (dx < mx[i]) return 4;
    if (dy > my[i]) return 3;
    if (dy < my[i]) return 1;
    return 0;
  endfunction

  task automatic model_reset(int i);
    for (int p = 0; p < 5; p++) begin
      mq[i][p].delete();
      mcred[i][p] = 4;
      mptr[i][p]  = 0;
      ed[i][p]    = '0;
    end
    ev[i] = '0;
    ec[i] = '0;
    ee[i] = 1'b0;
  endtask

  task automatic model_edge(int i);
    int r[5];
    int s;
    logic [4:0] pop, send;
    pop  = '0;
    send = '0;
    for (int p = 0; p < 5; p++)
      r[p] = (mq[i][p].size() > 0) ? route_of(i, mq[i][p][0]) : -1;
    for (int p = 0; p < 5; p++)
      if (r[p] >= 0 && !men[i][r[p]]) begin
        pop[p] = 1'b1;
        ee[i]  = 1'b1;
      end
    for (int o = 0; o < 5; o++)
      if (men[i][o] && mcred[i][o] > 0)
        for (int k = 0; k < 5; k++) begin
          s = (mptr[i][o] + k) % 5;
          if (!send[o] && r[s] == o) begin
            send[o]    = 1'b1;
            pop[s]     = 1'b1;
            ed[i][o]   = mq[i][s][0];
            mptr[i][o] = (s + 1) % 5;
          end
        end
    for (int o = 0; o < 5; o++) begin
      if (send[o] && !cin[i][o]) mcred[i][o]--;
      else if (!send[o] && cin[i][o] && mcred[i][o] < 4) mcred[i][o]++;
    end
    for (int p = 0; p < 5; p++)
      if (pop[p]) void'(mq[i][p].pop_front());
    for (int p = 0; p < 5; p++)
      if (men[i][p] && vin[i][p]) begin
        if (mq[i][p].size() < 4) mq[i][p].push_back(din[i][p*16 +: 16]);
        else ee[i] = 1'b1;
      end
    ev[i] = send;
    ec[i] = pop;
  endtask

  task automatic compare_all(int i);
    logic [79:0] exp_d;
    for (int o = 0; o < 5; o++) exp_d[o*16 +: 16] = ed[i][o];
    check($sformatf("u%0d_valid_o", i),  80'(vout[i]), 80'(ev[i]));
    check($sformatf("u%0d_credit_o", i), 80'(cout[i]), 80'(ec[i]));
    check($sformatf("u%0d_err_o", i),    80'(err[i]),  80'(ee[i]));
    check($sformatf("u%0d_data_o", i),   dout[i],      exp_d);
  endtask

  // Inputs are set at the falling edge; one rising edge; outputs checked at the next fall.
  task automatic step();
    for (int i = 0; i < 2; i++) cin[i] = man[i] | (ev[i] & amask[i]);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare_all(0);
    compare_all(1);
    for (int i = 0; i < 2; i++) begin
      vin[i] = '0;
      man[i] = '0;
    end
  endtask

  task automatic put(int i, int p, logic [15:0] f);
    vin[i][p] = 1'b1;
    din[i][p*16 +: 16] = f;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vin[i] = '0;
      man[i] = '0;
      cin[i] = '0;
    end
    #1;
    model_reset(0);
    model_reset(1);
    compare_all(0);
    compare_all(1);
    @(posedge clk);
    @(negedge clk);
    compare_all(0);
    compare_all(1);
    rst = 1'b0;
  endtask

  initial begin
    int cnt, first, last;
    logic [15:0] f;
    logic [3:0] src_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int in_tab[3]  = '{4, 3, 1};
    int dx_tab[3]  = '{3, 1, 1};
    int dy_tab[3]  = '{0, 0, 1};
    int out_tab[3] = '{2, 1, 0};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; vin[i] = '0; cin[i] = '0; man[i] = '0; amask[i] = 5'b11111;
      model_reset(i);
    end
    @(negedge clk);
    apply_reset();
    step();

    // 1: five flits L->E with no returning credit: four emerge, fifth waits for a credit
    amask[0] = 5'b11011;
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) put(0, 0, mk(3, 1, k));
      step();
      if (vout[0][2]) cnt++;
    end
    check("t1_four_sent", 80'(cnt), 80'(4));
    cnt = 0;
    man[0][2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (vout[0][2]) cnt++;
    end
    check("t1_fifth_after_credit", 80'(cnt), 80'(1));
    for (int k = 0; k < 5; k++) begin
      man[0][2] = 1'b1;
      step();
    end
    amask[0] = 5'b11111;

    // 2: single-flit routing and latency at (1,1)
    for (int t = 0; t < 3; t++) begin
      f = mk(dx_tab[t], dy_tab[t], 16 * t + 5);
      put(0, in_tab[t], f);
      step();
      check("t2_not_early", 80'(vout[0]), 80'(0));
      step();
      check("t2_valid_port", 80'(vout[0]), 80'(5'b1 << out_tab[t]));
      check("t2_payload", 80'(dout[0][out_tab[t]*16 +: 16]), 80'(f));
      check("t2_credit_port", 80'(cout[0]), 80'(5'b1 << in_tab[t]));
      step();
      step();
    end

    // 3: N, S, W all target L; grants rotate N->S->W->N with L busy every cycle
    first = -1;
    last  = -1;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) begin
        put(0, 1, mk(1, 1, 16 * 1 + k));
        put(0, 3, mk(1, 1, 16 * 3 + k));
        put(0, 4, mk(1, 1, 16 * 4 + k));
      end
      step();
      if (vout[0][0]) begin
        src_q.push_back(dout[0][7:4]);
        if (first < 0) first = k;
        last = k;
      end
    end
    check("t3_count", 80'(src_q.size()), 80'(12));
    check("t3_back_to_back", 80'(last - first + 1), 80'(12));
    for (int k = 0; k + 1 < src_q.size(); k++)
      check("t3_rotation", 80'(src_q[k+1]),
            80'((src_q[k] == 4'd1) ? 4'd3 : (src_q[k] == 4'd3) ? 4'd4 : 4'd1));

    // 4: corner-style tile: E->L delivery, then a westbound flit is discarded with err
    f = mk(1, 0, 16'h55);
    put(1, 2, f);
    put(1, 1, mk(1, 0, 16'h66));
    step();
    check("t4_not_early", 80'(vout[1]), 80'(0));
    step();
    check("t4_valid_local", 80'(vout[1]), 80'(5'b00001));
    check("t4_payload", 80'(dout[1][15:0]), 80'(f));
    check("t4_credit_e", 80'(cout[1]), 80'(5'b00100));
    check("t4_no_err_yet", 80'(err[1]), 80'(0));
    step();
    step();
    put(1, 2, mk(0, 0, 16'h77));
    step();
    step();
    check("t4_err", 80'(err[1]), 80'(1));
    check("t4_credit_drop", 80'(cout[1]), 80'(5'b00100));
    check("t4_nothing_sent", 80'(vout[1]), 80'(0));
    step();

    // 5: overflow with E output out of credit, then in-order delivery as credits return
    amask[0] = 5'b11011;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) put(0, 0, mk(3, 1, 16'h80 + k));
      step();
    end
    check("t5_err_before", 80'(err[0]), 80'(0));
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      f = mk(3, 1, 16'h100 + k);
      if (k < 4) exp_q.push_back(f);
      put(0, 0, f);
      step();
      if (vout[0][2]) cnt++;
    end
    check("t5_blocked", 80'(cnt), 80'(0));
    check("t5_err", 80'(err[0]), 80'(1));
    for (int k = 0; k < 8; k++) begin
      if (k < 4) man[0][2] = 1'b1;
      step();
      if (vout[0][2]) got_q.push_back(dout[0][47:32]);
    end
    check("t5_delivered", 80'(got_q.size()), 80'(4));
    for (int k = 0; k < got_q.size() && k < 4; k++)
      check("t5_order", 80'(got_q[k]), 80'(exp_q[k]));

    // 6: reset with three flits buffered behind the exhausted E output
    for (int k = 0; k < 3; k++) begin
      put(0, 0, mk(3, 1, 16'h200 + k));
      step();
    end
    step();
    apply_reset();
    check("t6_valid_clear", 80'(vout[0]), 80'(0));
    check("t6_credit_clear", 80'(cout[0]), 80'(0));
    check("t6_err_clear", 80'(err[0]), 80'(0));
    amask[0] = 5'b11111;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      cnt += int'(vout[0] != 0) + int'(cout[0] != 0);
    end
    check("t6_nothing_after", 80'(cnt), 80'(0));

    // random traffic on both tiles, checked cycle by cycle against the model
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0)
        for (int i = 0; i < 2; i++) amask[i] = 5'($urandom);
      for (int i = 0; i < 2; i++) begin
        man[i] = 5'($urandom) & 5'($urandom);
        for (int p = 0; p < 5; p++)
          if ($urandom_range(0, 99) < 40)
            put(i, p, mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1023)));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
